// File: rtl/microwave_if.sv
// Bundle between the microwave controller and its neighbours: control levels,
// 1 Hz tick, keypad-entry digits from timer_input, and the display/magnetron outputs.
//   slave  : controller side (takes controls and digits, drives time/mag_on/done/state)
//   master : environment side (keypad, buttons, door switch, tick source)
interface microwave_if;
  logic       tick_1hz;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       loadn;
  logic [3:0] units_of_seconds_in;
  logic [3:0] tens_of_seconds_in;
  logic [3:0] units_of_minutes_in;
  logic [3:0] units_of_seconds;
  logic [3:0] tens_of_seconds;
  logic [3:0] units_of_minutes;
  logic       mag_on;
  logic       done;
  logic       entry_enablen;
  logic [1:0] state;

  modport master (
    output tick_1hz, startn, stopn, clearn, door_closed, loadn,
    output units_of_seconds_in, tens_of_seconds_in, units_of_minutes_in,
    input  units_of_seconds, tens_of_seconds, units_of_minutes,
    input  mag_on, done, entry_enablen, state
  );

  modport slave (
    input  tick_1hz, startn, stopn, clearn, door_closed, loadn,
    input  units_of_seconds_in, tens_of_seconds_in, units_of_minutes_in,
    output units_of_seconds, tens_of_seconds, units_of_minutes,
    output mag_on, done, entry_enablen, state
  );
endinterface

// File: rtl/microwave_controller.sv
// Cook-cycle sequencer: captures an M:SS time from timer_input, counts it down in BCD
// on the 1 Hz tick while the magnetron is on, and handles start/stop/door/clear events.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   mw_io     : microwave_if.slave (controls, entry digits, time/mag_on/done/state outputs)
// Same-cycle priority: clear > (door open | stop) > start > tick > load.
module microwave_controller #(
  parameter int unsigned DONE_TICKS = 3
) (
  input logic        clk,
  input logic        rst,
  microwave_if.slave mw_io
);

  localparam int unsigned CntW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCook  = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        us_q, us_d;
  logic [3:0]        ts_q, ts_d;
  logic [3:0]        um_q, um_d;
  logic              mag_q, mag_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic time_zero;
  logic time_one;
  logic door_or_stop;

  assign time_zero    = (us_q == 4'd0) && (ts_q == 4'd0) && (um_q == 4'd0);
  assign time_one     = (us_q == 4'd1) && (ts_q == 4'd0) && (um_q == 4'd0);
  assign door_or_stop = !mw_io.door_closed || !mw_io.stopn;

  always_comb begin
    state_d = state_q;
    us_d    = us_q;
    ts_d    = ts_q;
    um_d    = um_q;
    mag_d   = mag_q;
    done_d  = done_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        mag_d  = 1'b0;
        done_d = 1'b0;
        if (!mw_io.clearn) begin
          us_d = 4'd0;
          ts_d = 4'd0;
          um_d = 4'd0;
        end else if (!mw_io.startn && mw_io.door_closed && !time_zero) begin
          state_d = StCook;
          mag_d   = 1'b1;
        end else if (!mw_io.loadn) begin
          // Out-of-range keypad digits saturate to the largest legal BCD digit.
          us_d = (mw_io.units_of_seconds_in > 4'd9) ? 4'd9 : mw_io.units_of_seconds_in;
          ts_d = (mw_io.tens_of_seconds_in  > 4'd5) ? 4'd5 : mw_io.tens_of_seconds_in;
          um_d = (mw_io.units_of_minutes_in > 4'd9) ? 4'd9 : mw_io.units_of_minutes_in;
        end
      end

      StCook: begin
        if (!mw_io.clearn) begin
          state_d = StIdle;
          mag_d   = 1'b0;
          us_d    = 4'd0;
          ts_d    = 4'd0;
          um_d    = 4'd0;
        end else if (door_or_stop) begin
          state_d = StPause;
          mag_d   = 1'b0;
        end else if (mw_io.tick_1hz) begin
          if (time_one) begin
            state_d = StDone;
            mag_d   = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            us_d    = 4'd0;
          end else if (!time_zero) begin
            // BCD decrement with borrow: seconds 0->9, tens 0->5, then minutes.
            if (us_q != 4'd0) begin
              us_d = us_q - 4'd1;
            end else begin
              us_d = 4'd9;
              if (ts_q != 4'd0) begin
                ts_d = ts_q - 4'd1;
              end else begin
                ts_d = 4'd5;
                um_d = um_q - 4'd1;
              end
            end
          end
        end
      end

      StPause: begin
        if (!mw_io.clearn) begin
          state_d = StIdle;
          us_d    = 4'd0;
          ts_d    = 4'd0;
          um_d    = 4'd0;
        end else if (!door_or_stop && !mw_io.startn) begin
          state_d = StCook;
          mag_d   = 1'b1;
        end
      end

      StDone: begin
        if (!mw_io.clearn || !mw_io.startn || !mw_io.door_closed) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (mw_io.tick_1hz) begin
          if (cnt_q == CntW'(DONE_TICKS - 1)) begin
            state_d = StIdle;
            done_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      us_q    <= 4'd0;
      ts_q    <= 4'd0;
      um_q    <= 4'd0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      us_q    <= us_d;
      ts_q    <= ts_d;
      um_q    <= um_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mw_io.units_of_seconds = us_q;
  assign mw_io.tens_of_seconds  = ts_q;
  assign mw_io.units_of_minutes = um_q;
  assign mw_io.mag_on           = mag_q;
  assign mw_io.done             = done_q;
  assign mw_io.state            = state_q;
  assign mw_io.entry_enablen    = (state_q == StIdle);

endmodule

// File: tb/tb_microwave_controller.sv
// Directed, table-driven bench for microwave_controller plus hand-written sequences for
// long countdowns, pause/resume, DONE exits and asynchronous reset.
module tb_microwave_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  microwave_if mw ();

  microwave_controller #(.DONE_TICKS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .mw_io (mw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door;
    logic       loadn;
    logic       tick;
    logic [3:0] um;
    logic [3:0] ts;
    logic [3:0] us;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] st;
    logic [3:0] um;
    logic [3:0] ts;
    logic [3:0] us;
    logic       mag;
    logic       done;
  } vec_t;

  function automatic in_t mki(input logic s, input logic p, input logic c, input logic d,
                              input logic l, input logic t,
                              input logic [3:0] um, input logic [3:0] ts,
                              input logic [3:0] us);
    in_t r;
    r.startn = s; r.stopn = p; r.clearn = c; r.door = d; r.loadn = l; r.tick = t;
    r.um = um; r.ts = ts; r.us = us;
    return r;
  endfunction

  function automatic in_t idle_in();
    return mki(1, 1, 1, 1, 1, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [1:0] st, input logic [3:0] um,
                               input logic [3:0] ts, input logic [3:0] us,
                               input logic mag, input logic done);
    vec_t v;
    v.i = i; v.st = st; v.um = um; v.ts = ts; v.us = us; v.mag = mag; v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] st, input logic [3:0] um,
                           input logic [3:0] ts, input logic [3:0] us,
                           input logic mag, input logic done);
    check({tag, " state"}, 16'(mw.state), 16'(st));
    check({tag, " time"},
          16'({mw.units_of_minutes, mw.tens_of_seconds, mw.units_of_seconds}),
          16'({um, ts, us}));
    check({tag, " mag_on"}, 16'(mw.mag_on), 16'(mag));
    check({tag, " done"}, 16'(mw.done), 16'(done));
    check({tag, " entry_enablen"}, 16'(mw.entry_enablen), 16'(st == 2'd0));
  endtask

  // Apply one cycle of inputs and return #1 after the sampling edge.
  task automatic step(input in_t i);
    mw.startn              = i.startn;
    mw.stopn               = i.stopn;
    mw.clearn              = i.clearn;
    mw.door_closed         = i.door;
    mw.loadn               = i.loadn;
    mw.tick_1hz            = i.tick;
    mw.units_of_minutes_in = i.um;
    mw.tens_of_seconds_in  = i.ts;
    mw.units_of_seconds_in = i.us;
    @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [3:0] um, input logic [3:0] ts, input logic [3:0] us);
    step(mki(1, 1, 1, 1, 0, 0, um, ts, us));
  endtask

  task automatic tick();
    in_t i;
    i = idle_in();
    i.tick = 1'b1;
    step(i);
  endtask

  task automatic start();
    in_t i;
    i = idle_in();
    i.startn = 1'b0;
    step(i);
  endtask

  // Seconds-to-digits reference used for the long countdown sequences.
  task automatic check_secs(input string tag, input int secs, input logic [1:0] st,
                            input logic mag, input logic done);
    check_out(tag, st, 4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10), mag, done);
  endtask

  vec_t vecs[30];

  initial begin
    // Table: inputs for one cycle, expected outputs after that edge.
    vecs[0]  = mkv(mki(1, 1, 1, 1, 0, 0, 9, 7, 12), 0, 9, 5, 9, 0, 0);  // clamped load
    vecs[1]  = mkv(mki(0, 1, 0, 1, 1, 0, 0, 0, 0),  0, 0, 0, 0, 0, 0);  // clear beats start
    vecs[2]  = mkv(mki(0, 1, 1, 1, 1, 0, 0, 0, 0),  0, 0, 0, 0, 0, 0);  // start at 0:00
    vecs[3]  = mkv(mki(1, 1, 1, 1, 0, 0, 0, 1, 0),  0, 0, 1, 0, 0, 0);  // load 0:10
    vecs[4]  = mkv(mki(0, 1, 1, 0, 1, 0, 0, 0, 0),  0, 0, 1, 0, 0, 0);  // start, door open
    vecs[5]  = mkv(mki(0, 1, 1, 1, 1, 1, 0, 0, 0),  1, 0, 1, 0, 1, 0);  // start+tick
    vecs[6]  = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  1, 0, 0, 9, 1, 0);  // borrow 0:10->0:09
    vecs[7]  = mkv(mki(1, 1, 1, 1, 0, 0, 5, 5, 5),  1, 0, 0, 9, 1, 0);  // load ignored
    vecs[8]  = mkv(mki(1, 0, 1, 1, 1, 1, 0, 0, 0),  2, 0, 0, 9, 0, 0);  // stop+tick
    vecs[9]  = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  2, 0, 0, 9, 0, 0);  // tick in pause
    vecs[10] = mkv(mki(0, 1, 1, 0, 1, 0, 0, 0, 0),  2, 0, 0, 9, 0, 0);  // start, door open
    vecs[11] = mkv(mki(0, 1, 1, 1, 1, 0, 0, 0, 0),  1, 0, 0, 9, 1, 0);  // resume
    vecs[12] = mkv(mki(1, 1, 0, 1, 1, 1, 0, 0, 0),  0, 0, 0, 0, 0, 0);  // clear+tick
    vecs[13] = mkv(mki(1, 1, 1, 1, 0, 0, 0, 0, 1),  0, 0, 0, 1, 0, 0);  // load 0:01
    vecs[14] = mkv(mki(0, 1, 1, 1, 1, 0, 0, 0, 0),  1, 0, 0, 1, 1, 0);
    vecs[15] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  3, 0, 0, 0, 0, 1);  // 0:01 tick -> DONE
    vecs[16] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  3, 0, 0, 0, 0, 1);  // done tick 1
    vecs[17] = mkv(mki(1, 1, 1, 1, 1, 0, 0, 0, 0),  3, 0, 0, 0, 0, 1);
    vecs[18] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  3, 0, 0, 0, 0, 1);  // done tick 2
    vecs[19] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  0, 0, 0, 0, 0, 0);  // done tick 3
    vecs[20] = mkv(mki(1, 1, 1, 1, 0, 0, 1, 0, 0),  0, 1, 0, 0, 0, 0);  // load 1:00
    vecs[21] = mkv(mki(0, 1, 1, 1, 1, 0, 0, 0, 0),  1, 1, 0, 0, 1, 0);
    vecs[22] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  1, 0, 5, 9, 1, 0);  // minute borrow
    vecs[23] = mkv(mki(1, 1, 1, 1, 1, 1, 0, 0, 0),  1, 0, 5, 8, 1, 0);
    vecs[24] = mkv(mki(1, 1, 1, 0, 1, 1, 0, 0, 0),  2, 0, 5, 8, 0, 0);  // door open+tick
    vecs[25] = mkv(mki(0, 1, 1, 0, 1, 0, 0, 0, 0),  2, 0, 5, 8, 0, 0);  // held start
    vecs[26] = mkv(mki(0, 1, 1, 1, 1, 0, 0, 0, 0),  1, 0, 5, 8, 1, 0);  // door closes
    vecs[27] = mkv(mki(1, 1, 0, 1, 1, 0, 0, 0, 0),  0, 0, 0, 0, 0, 0);
    vecs[28] = mkv(mki(1, 1, 1, 1, 0, 0, 15, 3, 4), 0, 9, 3, 4, 0, 0);  // minute clamp
    vecs[29] = mkv(mki(1, 1, 0, 1, 1, 0, 0, 0, 0),  0, 0, 0, 0, 0, 0);

    // Reset state, checked before any clock edge.
    step_inputs_idle();
    #2 rst = 1'b1;
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(idle_in());
    check_out("post_reset", 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      step(vecs[n].i);
      check_out($sformatf("vec%0d", n), vecs[n].st, vecs[n].um, vecs[n].ts, vecs[n].us,
                vecs[n].mag, vecs[n].done);
    end

    // 1:05 full countdown: 65 ticks to DONE.
    load_time(1, 0, 5);
    start();
    check_secs("cd_start", 65, 1, 1, 0);
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k < 65) check_secs($sformatf("cd_t%0d", k), 65 - k, 1, 1, 0);
      else        check_secs("cd_end", 0, 3, 0, 1);
    end
    step(mki(1, 1, 0, 1, 1, 0, 0, 0, 0));
    check_out("cd_clear", 0, 0, 0, 0, 0, 0);

    // 0:30 with a door-open pause after 5 ticks.
    load_time(0, 3, 0);
    start();
    for (int k = 0; k < 5; k++) tick();
    check_secs("pz_run", 25, 1, 1, 0);
    step(mki(1, 1, 1, 0, 1, 0, 0, 0, 0));
    check_secs("pz_open", 25, 2, 0, 0);
    for (int k = 0; k < 3; k++) step(mki(1, 1, 1, 0, 1, 1, 0, 0, 0));
    check_secs("pz_hold", 25, 2, 0, 0);
    start();
    check_secs("pz_resume", 25, 1, 1, 0);
    for (int k = 0; k < 24; k++) tick();
    check_secs("pz_last", 1, 1, 1, 0);
    tick();
    check_secs("pz_done", 0, 3, 0, 1);

    // DONE exits immediately on start, then on door open.
    start();
    check_out("dn_start_exit", 0, 0, 0, 0, 0, 0);
    load_time(0, 0, 1);
    start();
    tick();
    check_out("dn_reenter", 3, 0, 0, 0, 0, 1);
    step(mki(1, 1, 1, 0, 1, 0, 0, 0, 0));
    check_out("dn_door_exit", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cook at 0:42: outputs clear before the next edge.
    load_time(0, 4, 2);
    start();
    check_out("ar_cook", 1, 0, 4, 2, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_out("ar_async", 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(idle_in());
    check_out("ar_after", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic step_inputs_idle();
    mw.startn              = 1'b1;
    mw.stopn               = 1'b1;
    mw.clearn              = 1'b1;
    mw.door_closed         = 1'b1;
    mw.loadn               = 1'b1;
    mw.tick_1hz            = 1'b0;
    mw.units_of_minutes_in = 4'd0;
    mw.tens_of_seconds_in  = 4'd0;
    mw.units_of_seconds_in = 4'd0;
  endtask

endmodule

// File: doc/microwave_controller.md
# microwave_controller

Cook-cycle sequencer for the microwave. It captures the MM:SS value entered through timer_input and counts it down in BCD on a 1 Hz tick. It gates the magnetron on start/stop/door/clear events and signals completion. It sits between timer_input (keypad entry) and the display/magnetron drivers, and owns timer_input's enable.

## Interface
- DONE_TICKS, 3: number of tick_1hz pulses `done` stays high in DONE before auto-return to IDLE (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-clk-wide pulse, once per second
- startn  in  1  start request, active-low level, sampled every clk
- stopn  in  1  pause request, active-low level
- clearn  in  1  cancel/clear request, active-low level
- door_closed  in  1  1 = door closed
- loadn  in  1  active-low load strobe from timer_input
- units_of_seconds_in / tens_of_seconds_in / units_of_minutes_in  in  4 each  BCD entry digits from timer_input
- units_of_seconds / tens_of_seconds / units_of_minutes  out  4 each  remaining time, BCD, registered
- mag_on  out  1  magnetron enable, registered
- done  out  1  cook-complete indicator, registered
- entry_enablen  out  1  drives timer_input enablen; 1 only in IDLE (decoded from state register)
- state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3

## Operation
- Reset (async, immediate):
  - state=IDLE, time=0:00, mag_on=0, done=0, entry_enablen=1.
- IDLE:
  - When loadn=0, load the time register from the input digits.
  - Load clamps: units_of_seconds >9 → 9, tens_of_seconds >5 → 5, units_of_minutes >9 → 9.
  - clearn=0 → time=0:00.
  - startn=0 with door_closed=1 and time≠0:00 → COOK.
  - Start with time=0:00 or door open is ignored.
- COOK:
  - mag_on=1; each tick_1hz decrements time.
  - door_closed=0 or stopn=0 → PAUSE.
  - clearn=0 → IDLE with time=0:00.
  - A tick with time=0:01 → time=0:00, state DONE.
- PAUSE:
  - mag_on=0; ticks ignored; time held.
  - startn=0 with door_closed=1 → COOK.
  - clearn=0 → IDLE with time=0:00.
- DONE:
  - done=1, mag_on=0, time=0:00.
  - Count ticks; after DONE_TICKS ticks → IDLE, done=0.
  - clearn=0, startn=0 or door_closed=0 → IDLE immediately.
- Same-cycle event priority: clear > (door open | stop) > start > tick > load.
- BCD decrement:
  - units_of_seconds 0→9 with borrow; tens_of_seconds 0→5 with borrow; units_of_minutes decrements on borrow.
  - 0:00 is never decremented; no wrap to 9:59.
- loadn is ignored outside IDLE.

## Timing
- All outputs except entry_enablen are registered and update on the clk edge that samples the event (1-cycle latency).
- entry_enablen is decoded combinationally from the state register, so it changes with state.
- COOK entry: mag_on=1 on the edge after startn is sampled low.
- A tick in the same cycle as start is not counted.
- A tick at 0:01 sets time=0:00, mag_on=0, done=1 and state=DONE on the same edge.
- A tick in the same cycle as door open or stop: no decrement; PAUSE entered.
- Held startn/stopn levels re-evaluate every cycle. Example: startn held low in PAUSE with the door open resumes on the first cycle the door closes.
- DONE tick counter clears on DONE entry; the first counted tick is the first one after entry.
- rst asserted mid-COOK: mag_on drops asynchronously, with no wait for clk.

## Test plan
- Reset, load 1:05 (loadn pulse), startn pulse, 65 ticks → mag_on high from the cycle after start. Time steps 1:05→1:04→…→1:00→0:59→…→0:01→0:00. done=1 and state=3 on the 65th tick edge; mag_on low.
- Load 0:30, start, 5 ticks, door_closed=0 → time 0:25, state=PAUSE, mag_on=0. 3 extra ticks → time still 0:25. Door closed, startn → COOK, 25 ticks → DONE.
- Start with time 0:00, and start with the door open at 0:10 → state stays IDLE, mag_on stays 0.
- Load inputs 9,7,12 (min, tens, units) → register reads 9:59. In COOK, same-cycle clearn+tick → IDLE, 0:00, no decrement.
- Reach DONE, apply DONE_TICKS=3 ticks → done high for exactly 3 ticks, then IDLE with entry_enablen=1. Repeat and pulse startn in DONE → immediate IDLE.
- rst asserted asynchronously mid-COOK at 0:42 → mag_on=0, time=0:00 and state=IDLE before the next clk edge.
